// File: rtl/clz_skip_divider_if.sv
// Operand/result bundle for the CLZ-skip divider.
// master issues requests, slave computes.
interface clz_skip_divider_if #(
  parameter int DIV_WIDTH = 32,
  parameter int CLZW      = $clog2(DIV_WIDTH)
);
  logic                 start;
  logic [DIV_WIDTH-1:0] dividend;
  logic [DIV_WIDTH-1:0] divisor;
  logic [CLZW-1:0]      dividend_CLZ;
  logic [CLZW-1:0]      divisor_CLZ;
  logic                 divisor_is_zero;
  logic                 busy;
  logic                 done;
  logic [DIV_WIDTH-1:0] quotient;
  logic [DIV_WIDTH-1:0] remainder;

  modport master (
    output start, dividend, divisor,
    output dividend_CLZ, divisor_CLZ,
    output divisor_is_zero,
    input  busy, done, quotient, remainder
  );

  modport slave (
    input  start, dividend, divisor,
    input  dividend_CLZ, divisor_CLZ,
    input  divisor_is_zero,
    output busy, done, quotient, remainder
  );
endinterface

// File: rtl/clz_skip_divider.sv
// Radix-2 restoring divider that skips known-zero
// quotient bits using operand leading-zero counts.
module clz_skip_divider #(
  parameter int DIV_WIDTH = 32
) (
  input logic                clk,
  input logic                rst,
  clz_skip_divider_if.slave  io
);
  localparam int W    = DIV_WIDTH;
  localparam int CLZW = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [W-1:0]    quo;
  logic [W-1:0]    rem;
  logic [W-1:0]    dsh;
  logic [CLZW-1:0] cnt;
  logic [CLZW-1:0] shift;
  logic            fast;
  logic            ge;

  assign fast  = io.divisor_is_zero ||
                 (io.divisor_CLZ < io.dividend_CLZ);
  assign shift = io.divisor_CLZ - io.dividend_CLZ;
  assign ge    = rem >= dsh;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A new start always wins, even over a running op.
  always_comb begin
    state_nxt = state;
    if (io.start) begin
      state_nxt = fast ? FIN : RUN;
    end else begin
      unique case (state)
        IDLE:    state_nxt = IDLE;
        RUN:     state_nxt = (cnt == '0) ? FIN : RUN;
        FIN:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    io.busy = (state == RUN);
    io.done = (state == FIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quo <= '0;
      rem <= '0;
      dsh <= '0;
      cnt <= '0;
    end else if (io.start) begin
      rem <= io.dividend;
      cnt <= '0;
      if (io.divisor_is_zero) begin
        quo <= '1;
      end else if (fast) begin
        quo <= '0;
      end else begin
        quo <= '0;
        dsh <= io.divisor << shift;
        cnt <= shift;
      end
    end else if (state == RUN) begin
      quo <= {quo[W-2:0], ge};
      if (ge) rem <= rem - dsh;
      dsh <= dsh >> 1;
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end

  assign io.quotient  = quo;
  assign io.remainder = rem;
endmodule
